// File: rtl/ws_pkg.sv
// ws_pkg: shared ASCII opcodes and FSM state types for the whitespace loader
package ws_pkg;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_EOT = 8'h04;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
    typedef enum logic {LOAD, DONE} loader_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronizer and 8N1 receiver FSM with break hold-off
module uart_rx_core
    import ws_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    logic [1:0] sync;
    logic rxs, brk, brk_n, valid_n, err_n;
    uart_rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] sh, sh_n;
    assign rxs = sync[1];
    assign byte_data = sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            brk <= 1'b0;
            byte_valid <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            sync <= {sync[0], uart_rx};
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            sh <= sh_n;
            brk <= brk_n;
            byte_valid <= valid_n;
            frame_err_pulse <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        bit_n = bit_idx;
        sh_n = sh;
        brk_n = brk;
        valid_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                state_n = rxs ? IDLE : START;
            end
            START: if (cnt == HALF) begin
                cnt_n = '0;
                bit_n = '0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n = {rxs, sh[7:1]};
                bit_n = bit_idx + 3'd1;
                state_n = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (brk) begin
                // line held low after a bad stop bit: wait for idle before rearming
                cnt_n = '0;
                brk_n = !rxs;
                state_n = rxs ? IDLE : STOP;
            end else if (cnt == LAST) begin
                cnt_n = '0;
                valid_n = rxs;
                err_n = !rxs;
                brk_n = !rxs;
                state_n = rxs ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/ws_prog_loader.sv
// ws_prog_loader: UART loader writing whitespace opcodes into imem until EOT
module ws_prog_loader
    import ws_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 234,
    parameter int         ADDR_W       = 10,
    parameter logic [7:0] EOT_BYTE     = ASCII_EOT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    output logic              overflow,
    output logic              frame_err
);
    logic byte_valid, frame_err_pulse, keep, full, load, wr;
    logic [7:0] byte_data;
    loader_state_t state, state_n;
    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .frame_err_pulse(frame_err_pulse)
    );
    assign keep = byte_data == ASCII_SP || byte_data == ASCII_TAB || byte_data == ASCII_LF;
    assign full = prog_len[ADDR_W];
    assign load = state == LOAD;
    assign wr = load && byte_valid && keep && !full;
    assign load_done = state == DONE;
    always_comb state_n = (load && byte_valid && byte_data == EOT_BYTE) ? DONE : state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            mem_wen <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            prog_len <= '0;
            overflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            mem_wen <= wr;
            if (wr) begin
                mem_addr <= prog_len[ADDR_W-1:0];
                mem_wdata <= byte_data;
                prog_len <= prog_len + (ADDR_W + 1)'(1);
            end
            overflow <= overflow | (load && byte_valid && keep && full);
            frame_err <= frame_err | (load && frame_err_pulse);
        end
    end
endmodule

// File: tb/tb_ws_prog_loader.sv
// tb_ws_prog_loader: directed UART vectors with write scoreboard and end-of-load checks
module tb_ws_prog_loader;
    localparam int CPB = 8;
    localparam int AW = 4;
    logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
    logic mem_wen, load_done, overflow, frame_err;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [AW:0] prog_len;
    int vectors = 0, miscompares = 0;
    logic [AW+7:0] exp_q[$];
    logic prev_wen = 1'b0;

    ws_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .EOT_BYTE(8'h04)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_done(load_done),
        .prog_len(prog_len), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_wen) begin
            logic [AW+7:0] e;
            vectors++;
            if (prev_wen) begin
                miscompares++;
                $display("FAIL wen_consecutive: mem_wen high 2 cycles, required 1");
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr=%0d data=%02h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write: got %0d/%02h, required %0d/%02h", mem_addr, mem_wdata, e[AW+7:8], e[7:0]);
                end
            end
        end
        prev_wen = rst_n && mem_wen;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst_n = 1'b0;
        #3;
        check("rst_wen", mem_wen, 0);
        check("rst_outputs", {mem_addr, mem_wdata, load_done, prog_len, overflow, frame_err}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic finish_check(input string name, input int len, input logic ovf, input logic ferr);
        repeat (20) @(posedge clk);
        #2;
        check({name, "_done"}, load_done, 1);
        check({name, "_len"}, prog_len, len);
        check({name, "_ovf"}, overflow, ovf);
        check({name, "_ferr"}, frame_err, ferr);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        // basic program
        expect_wr(0, 8'h20); send(8'h20);
        expect_wr(1, 8'h20); send(8'h20);
        expect_wr(2, 8'h09); send(8'h09);
        expect_wr(3, 8'h0A); send(8'h0A);
        send(8'h04);
        finish_check("basic", 4, 0, 0);
        // bytes after load_done are ignored
        send(8'h20);
        finish_check("after_done", 4, 0, 0);

        do_reset();
        // comments dropped
        send(8'h41);
        expect_wr(0, 8'h20); send(8'h20);
        expect_wr(1, 8'h09); send(8'h09);
        send(8'h42);
        expect_wr(2, 8'h0A); send(8'h0A);
        send(8'h04);
        finish_check("comments", 3, 0, 0);

        do_reset();
        // empty program
        send(8'h04);
        finish_check("empty", 0, 0, 0);

        do_reset();
        // overflow: 16 fit, 17th is rejected without wrapping
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_wr(i, 8'h20);
            send(8'h20);
        end
        send(8'h04);
        finish_check("overflow", 16, 1, 0);

        do_reset();
        // bad stop bit
        send(8'h20, 1'b0);
        repeat (20) @(posedge clk);
        expect_wr(0, 8'h09); send(8'h09);
        send(8'h04);
        finish_check("frame", 1, 0, 1);

        do_reset();
        // short low glitch on idle line
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        expect_wr(0, 8'h0A); send(8'h0A);
        send(8'h04);
        finish_check("glitch", 1, 0, 0);

        do_reset();
        // reset mid-DATA of the second byte
        expect_wr(0, 8'h20); send(8'h20);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = i[0];
            repeat (CPB) @(posedge clk);
        end
        check("pre_rst_len", prog_len, 1);
        do_reset();
        expect_wr(0, 8'h09); send(8'h09);
        send(8'h04);
        finish_check("midreset", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ws_prog_loader.md
Name: ws_prog_loader

Overview:
- UART program loader sitting directly upstream of the whitespace core's instruction memory.
- Receives 8N1 serial bytes on uart_rx and keeps only whitespace opcodes: SP 0x20, TAB 0x09, LF 0x0A.
- Writes kept bytes sequentially into imem from address 0, then raises load_done so the core can leave reset and fetch from pc=0.
- All other bytes are treated as comments and dropped; 0x04 (EOT) ends the load.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); must be >= 4.
- ADDR_W, 10, imem address width; depth = 2**ADDR_W.
- EOT_BYTE, 8'h04, end-of-program marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- mem_wen  out  1  one-cycle imem write strobe
- mem_addr  out  ADDR_W  imem write address
- mem_wdata  out  8  imem write data (always SP/TAB/LF)
- load_done  out  1  level; program loaded, core may run
- prog_len  out  ADDR_W+1  number of bytes written
- overflow  out  1  sticky; program exceeded depth
- frame_err  out  1  sticky; a byte had stop bit = 0

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; asserting it at any time, including mid-byte, returns every state immediately.
- Reset values: mem_wen=0, mem_addr=0, mem_wdata=0, load_done=0, prog_len=0, overflow=0, frame_err=0. RX FSM goes to IDLE. Synchronizer flops reset to 1.
- Input synchronizer: uart_rx passes through 2 flops; all RX logic uses the synchronized value rxs.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: on rxs=0, clear the counter and go to START.
  - START: at count CLKS_PER_BIT/2-1, sample. If rxs=1 it was a glitch: return to IDLE, no byte. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into a byte register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1: byte_valid pulses for 1 cycle with byte_data.
    - rxs=0: set frame_err, emit no byte, and return to IDLE only once rxs=1 (no false start inside a break).
- Loader FSM, states LOAD, DONE:
  - LOAD, byte_valid with SP/TAB/LF:
    - If prog_len < 2**ADDR_W: next cycle mem_wen=1, mem_addr=prog_len[ADDR_W-1:0], mem_wdata=byte. prog_len increments in that same cycle.
    - Otherwise set overflow and do no write.
  - LOAD, byte_valid == EOT_BYTE: load_done=1 on the following cycle; go to DONE.
  - LOAD, any other byte: drop it; no state change.
  - DONE: all further bytes are ignored. load_done, prog_len and outputs hold until reset.
- Latency: mem_wen asserts exactly 1 cycle after byte_valid. load_done asserts 1 cycle after the EOT byte_valid.
- Max 1 write per byte, so back-to-back bytes never collide.
- mem_wen is never high for 2 consecutive cycles.
- Write data: the EOT byte itself is never written to imem.
- Boundaries:
  - Empty program (EOT first): load_done=1, prog_len=0.
  - Exactly 2**ADDR_W kept bytes: all written, overflow=0.
  - One more kept byte: overflow=1, no wrap to address 0.
  - Reset during DATA: the partial byte is discarded.

Decomposition:
- Shared package ws_pkg: ASCII_SP=8'h20, ASCII_TAB=8'h09, ASCII_LF=8'h0A, ASCII_EOT=8'h04.
- Shared package also holds the uart_rx_state_t enum (IDLE, START, DATA, STOP) and the loader_state_t enum (LOAD, DONE).
- Sub-module uart_rx_core: synchronizer plus RX FSM. Outputs byte_valid, byte_data and frame_err_pulse.
- ws_prog_loader instantiates uart_rx_core and holds the filter, address counter and loader FSM.

Test Plan (CLKS_PER_BIT=8, ADDR_W=4):
- Send "\x20\x20\x09\x0A\x04" -> writes at addrs 0..3, data 20,20,09,0A, one cycle each; load_done=1; prog_len=4.
- Send "A \tB\n" then 0x04 -> bytes 41,42 dropped; writes 20@0, 09@1, 0A@2; prog_len=3, frame_err=0.
- Send 17 SP bytes then 0x04 -> 16 writes to addrs 0..15; overflow=1; no 17th mem_wen; load_done=1, prog_len=16.
- Send 0x20 with stop bit driven 0, then idle high, then 0x09 and 0x04 -> frame_err=1; only 09@0 written; prog_len=1.
- Low pulse of 2 clks on idle line, then 0x0A and 0x04 -> glitch rejected; single write 0A@0.
- Assert rst_n=0 mid-DATA of second byte, release, send 0x09 and 0x04 -> all outputs were 0 during reset; 09 written at addr 0; prog_len=1.
- After load_done, send 0x20 -> no mem_wen; prog_len unchanged.
